// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter (core = port 0, debug = port 1) onto one memory request channel.
// Optional grant timeout/abort is built when MEM_ARBITER_TIMEOUT_EN is defined.
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_read_0,
    input  logic                    req_write_0,
    input  logic [ADDR_WIDTH-1:0]   addr_0,
    input  logic [DATA_WIDTH-1:0]   wdata_0,
    input  logic [DATA_WIDTH/8-1:0] byteen_0,
    input  logic                    req_read_1,
    input  logic                    req_write_1,
    input  logic [ADDR_WIDTH-1:0]   addr_1,
    input  logic [DATA_WIDTH-1:0]   wdata_1,
    input  logic [DATA_WIDTH/8-1:0] byteen_1,
    output logic                    complete_read_0,
    output logic                    complete_write_0,
    output logic                    complete_read_1,
    output logic                    complete_write_1,
    output logic                    err_0,
    output logic                    err_1,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_byteen,
    input  logic                    mem_complete_read,
    input  logic                    mem_complete_write,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [1:0]              dbg_state_o,
    output logic                    dbg_last_grant_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;

    logic                    pend_0, pend_1;
    logic                    sel, sel_rd, sel_wr, sel_pend, other_pend;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [DATA_WIDTH/8-1:0] sel_byteen;
    logic                    mem_done, fwd, timeout_hit, grant_port;

    assign pend_0     = req_read_0 | req_write_0;
    assign pend_1     = req_read_1 | req_write_1;
    assign sel        = (state_q == GRANT1);
    assign sel_rd     = sel ? req_read_1  : req_read_0;
    assign sel_wr     = sel ? req_write_1 : req_write_0;
    assign sel_pend   = sel ? pend_1      : pend_0;
    assign other_pend = sel ? pend_0      : pend_1;
    assign sel_addr   = sel ? addr_1      : addr_0;
    assign sel_wdata  = sel ? wdata_1     : wdata_0;
    assign sel_byteen = sel ? byteen_1    : byteen_0;
    assign mem_done   = mem_complete_read | mem_complete_write;
    // A withdrawn request or a reset cycle must never see a completion.
    assign fwd        = sel_pend & ~rst;

    assign rdata            = mem_rdata;
    assign dbg_state_o      = state_q;
    assign dbg_last_grant_o = last_grant_q;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_hit = (state_q != IDLE) & sel_pend & ~mem_done & (cnt_q == TO_VAL);

    // Any state change (entering or leaving a grant) restarts the count.
    always_comb begin
        cnt_d = '0;
        if (state_q != IDLE && state_d == state_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        grant_port       = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        mem_byteen       = '0;
        complete_read_0  = 1'b0;
        complete_write_0 = 1'b0;
        complete_read_1  = 1'b0;
        complete_write_1 = 1'b0;
        err_0            = 1'b0;
        err_1            = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_0 || pend_1) begin
                    grant_port   = (pend_0 && pend_1) ? ~last_grant_q : pend_1;
                    state_d      = grant_port ? GRANT1 : GRANT0;
                    last_grant_d = grant_port;
                end
            end
            GRANT0, GRANT1: begin
                // Read+write together is a write; an abort drops both strobes.
                mem_write  = sel_wr & ~timeout_hit;
                mem_read   = sel_rd & ~sel_wr & ~timeout_hit;
                mem_addr   = sel_addr;
                mem_wdata  = sel_wdata;
                mem_byteen = sel_byteen;
                if (sel) begin
                    complete_read_1  = fwd & mem_complete_read;
                    complete_write_1 = fwd & mem_complete_write;
                    err_1            = timeout_hit & ~rst;
                end else begin
                    complete_read_0  = fwd & mem_complete_read;
                    complete_write_0 = fwd & mem_complete_write;
                    err_0            = timeout_hit & ~rst;
                end
                if (!sel_pend) begin
                    state_d = IDLE;
                end else if (mem_done || timeout_hit) begin
                    if (other_pend) begin
                        state_d      = sel ? GRANT0 : GRANT1;
                        last_grant_d = ~sel;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
